mpc_pwm_gen: RTL
================

// Module: mpc_pwm_gen
// PURPOSE
//  Downstream of the MPC incremental-conductance duty controller.
//  Takes its Q16.16 duty command (0..1.0) plus data-valid, and double-buffers it.
//  Applies the command only at PWM period boundaries.
//  Drives complementary, dead-time-protected gate signals for the DC-DC switch pair.
//  Issues the periodic o_sample_req pulse that triggers the controller's next calculation (its i_calc_DV).
// PARAMETERS
//  CNT_W      16    width of period counter and compare values
//  PERIOD     1000  PWM period in i_clk cycles (2..2^CNT_W-1)
//  DEADTIME   4     min cycles both gates low around every transition (DEADTIME < PERIOD/2)
//  SAMPLE_PT  500   counter value at which o_sample_req pulses (0..PERIOD-1)
// PORTS
//  i_clk           in   1      clock
//  i_rst_n         in   1      synchronous active-low reset
//  i_en            in   1      1 = run; 0 = gates off, counter held at 0
//  i_duty          in   32     signed Q16.16 duty command; 0x00010000 = 100%
//  i_duty_dv       in   1      1-cycle strobe, i_duty valid
//  o_pwm_hi        out  1      high-side gate
//  o_pwm_lo        out  1      low-side gate (complement with dead time)
//  o_sample_req    out  1      1-cycle pulse at cnt==SAMPLE_PT
//  o_period_start  out  1      1-cycle pulse when cnt==0
//  o_cmp           out  CNT_W  active compare value in use
// BEHAVIOUR
//  Reset: cnt=0, cmp_active=0, pending cleared; all outputs 0 on the next edge.
//  Reset mid-period: aborts the period, gates low at once.
//  Counter: counts 0..PERIOD-1 and wraps while i_en=1.
//   i_en=0: cnt<=0 and both gates low; a pending command is kept; no sample/period pulses.
//  Duty intake is a 2-stage pipeline:
//   S1 (edge after i_duty_dv): clamp. i_duty<0 -> 0; i_duty>0x10000 -> 0x10000.
//   S2: cmp_pend = (clamped * PERIOD) >> 16. Product is 48-bit unsigned; result truncated to CNT_W.
//   pend_rdy is set at S2.
//  Back-to-back dv: last command wins; it overwrites any pending value.
//  Load: when cnt==PERIOD-1 && pend_rdy -> cmp_active<=cmp_pend, pend_rdy<=0.
//   The new value governs the period starting at the next cnt==0.
//   A dv arriving within 2 cycles of the boundary is applied one period later.
//  Raw PWM: raw = (cnt < cmp_active). cmp=0 -> raw always 0; cmp=PERIOD -> raw always 1.
//  Dead time: a dt counter resets on every raw edge and saturates at DEADTIME.
//   o_pwm_hi = raw  && dt==DEADTIME
//   o_pwm_lo = !raw && dt==DEADTIME
//   o_pwm_hi and o_pwm_lo are never high in the same cycle, including across reset and i_en toggles.
//  Typical period (0<cmp<PERIOD, previous period ended raw=0):
//   o_pwm_hi high for cnt in [DEADTIME, cmp-1].
//   o_pwm_lo high for cnt in [cmp+DEADTIME, PERIOD-1].
//   If cmp<=DEADTIME, o_pwm_hi never asserts.
//  100% duty: o_pwm_hi stays continuously high; no lo pulses.
//  0% duty: o_pwm_lo stays continuously high.
//  o_sample_req / o_period_start: registered; high exactly one cycle per period.
//  o_cmp: mirrors cmp_active.
// TESTING (bench params PERIOD=20, DEADTIME=2, SAMPLE_PT=10)
//  1 Reset held 3 cycles with i_en=1 -> all outputs 0, o_cmp=0.
//    After release: o_pwm_lo high from cnt=2; o_sample_req every 20 cycles.
//  2 i_duty=0x00008000 (0.5) strobed mid-period -> o_cmp=10 from next cnt==0.
//    o_pwm_hi at cnt 2..9; o_pwm_lo at cnt 12..19.
//  3 i_duty=0xFFFF0000 (-1.0) -> o_cmp=0, hi never asserts.
//    i_duty=0x00018000 (1.5) -> o_cmp=20, hi continuous.
//  4 Two strobes 1 cycle apart (0.25 then 0.75) -> only o_cmp=15 is applied.
//    Strobe at cnt==19 -> applied one period later.
//  5 Every cycle: assert !(o_pwm_hi && o_pwm_lo).
//    Each hi/lo handoff has >=2 cycles with both low.
//  6 i_en dropped mid-period -> both gates low next cycle, cnt=0, pulses stop.
//    Pending 0.5 is kept and applied after i_en returns.

Source files
------------

// File: rtl/mpc_pwm_gen_if.sv
// Duty-command channel from the MPC controller into the PWM generator.
// duty_dv is a one-cycle valid strobe qualifying duty; there is no ready, the sink accepts every strobe.
interface mpc_pwm_gen_if;
    logic [31:0] duty;
    logic        duty_dv;

    modport master (output duty, output duty_dv);
    modport slave  (input  duty, input  duty_dv);
endinterface

// File: rtl/mpc_pwm_gen.sv
// Complementary dead-time PWM generator with a double-buffered Q16.16 duty command,
// period-boundary updates and a periodic sample request for the upstream controller.
module mpc_pwm_gen #(
    parameter int CNT_W     = 16,
    parameter int PERIOD    = 1000,
    parameter int DEADTIME  = 4,
    parameter int SAMPLE_PT = 500
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    mpc_pwm_gen_if.slave     duty_if,
    output logic             o_pwm_hi,
    output logic             o_pwm_lo,
    output logic             o_sample_req,
    output logic             o_period_start,
    output logic [CNT_W-1:0] o_cmp
);

    localparam int DT_W = $clog2(DEADTIME + 2);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] SAMPLE = CNT_W'(SAMPLE_PT);
    localparam logic [DT_W-1:0]  DT     = DT_W'(DEADTIME);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cmp_active_q;
    logic [CNT_W-1:0] cmp_pend_q;
    logic             pend_rdy_q;
    logic [16:0]      clamp_q;
    logic             s1_vld_q;
    logic             raw_q;
    logic [DT_W-1:0]  dt_q;
    logic             run_q;

    logic [16:0]      duty_clamped;
    logic [47:0]      prod;
    logic [CNT_W-1:0] cmp_calc;
    logic             raw;
    logic [DT_W-1:0]  dt_cur;

    always_comb begin
        duty_clamped = duty_if.duty[16:0];
        if (duty_if.duty[31])
            duty_clamped = '0;
        else if (duty_if.duty > 32'h0001_0000)
            duty_clamped = 17'h1_0000;
    end

    assign prod     = 48'(clamp_q) * 48'(PERIOD);
    assign cmp_calc = CNT_W'(prod >> 16);
    assign raw      = (cnt_q < cmp_active_q);

    // First running cycle after reset or enable counts as a raw edge, so the
    // gate that comes up always waits out a full dead time.
    always_comb begin
        if (!run_q || (raw != raw_q))
            dt_cur = '0;
        else if (dt_q == DT)
            dt_cur = DT;
        else
            dt_cur = dt_q + DT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q          <= '0;
            cmp_active_q   <= '0;
            cmp_pend_q     <= '0;
            pend_rdy_q     <= 1'b0;
            clamp_q        <= '0;
            s1_vld_q       <= 1'b0;
            raw_q          <= 1'b0;
            dt_q           <= '0;
            run_q          <= 1'b0;
            o_pwm_hi       <= 1'b0;
            o_pwm_lo       <= 1'b0;
            o_sample_req   <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            s1_vld_q <= duty_if.duty_dv;
            if (duty_if.duty_dv)
                clamp_q <= duty_clamped;

            if (i_en && (cnt_q == LAST) && pend_rdy_q) begin
                cmp_active_q <= cmp_pend_q;
                pend_rdy_q   <= 1'b0;
            end
            // A result arriving on the load edge stays pending for the next period.
            if (s1_vld_q) begin
                cmp_pend_q <= cmp_calc;
                pend_rdy_q <= 1'b1;
            end

            if (i_en) begin
                cnt_q          <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
                run_q          <= 1'b1;
                raw_q          <= raw;
                dt_q           <= dt_cur;
                o_pwm_hi       <= raw && (dt_cur == DT);
                o_pwm_lo       <= !raw && (dt_cur == DT);
                o_sample_req   <= (cnt_q == SAMPLE);
                o_period_start <= (cnt_q == '0);
            end else begin
                cnt_q          <= '0;
                run_q          <= 1'b0;
                raw_q          <= 1'b0;
                dt_q           <= '0;
                o_pwm_hi       <= 1'b0;
                o_pwm_lo       <= 1'b0;
                o_sample_req   <= 1'b0;
                o_period_start <= 1'b0;
            end
        end
    end

    assign o_cmp = cmp_active_q;

endmodule
